decode_ctrl_pipe: RTL and testbench

Pipelined successor to the combinational control decoder. It decodes one instruction per cycle and registers the full control bundle into the ID/EX pipeline register. It detects load-use hazards and inserts a parametrised number of bubbles. It also handles EX-stage flush requests from branch/jump resolution and latches HLT as a sticky pipeline freeze. It sits between the IF/ID instruction register and the EX stage.

---
 rtl/decode_ctrl_pipe.sv | 241 ++++++++++++++++++++++++
 tb/tb_decode_ctrl_pipe.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: per-cycle instruction decode into a registered ID/EX
// control bundle, with load-use bubble insertion, EX flush and sticky halt.
module decode_ctrl_pipe #(
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned REG_AW   = 4,
  parameter int unsigned LINK_REG = 15,
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               instr_vld,
  input  logic               flush,
  output logic               id_stall,
  output logic               hlt,
  output logic               ex_vld,
  output logic               ex_rdEn1,
  output logic               ex_rdEn2,
  output logic               ex_wrRegEn,
  output logic [REG_AW-1:0]  ex_rdReg1,
  output logic [REG_AW-1:0]  ex_rdReg2,
  output logic [REG_AW-1:0]  ex_wrReg,
  output logic               ex_memRd,
  output logic               ex_memWr,
  output logic               ex_mem2reg,
  output logic               ex_sawBr,
  output logic               ex_sawJ,
  output logic               ex_aluSrc,
  output logic               ex_condZ,
  output logic [3:0]         ex_aluOp,
  output logic [3:0]         ex_shAmt
);

  localparam int unsigned OPC_W  = 4;
  localparam int unsigned SCNT_W = 3;

  // Opcode encodings shared with the rest of the core
  localparam logic [OPC_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OPC_W-1:0] OP_ADDZ = 4'h1;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'h2;
  localparam logic [OPC_W-1:0] OP_AND  = 4'h3;
  localparam logic [OPC_W-1:0] OP_NOR  = 4'h4;
  localparam logic [OPC_W-1:0] OP_SLL  = 4'h5;
  localparam logic [OPC_W-1:0] OP_SRL  = 4'h6;
  localparam logic [OPC_W-1:0] OP_SRA  = 4'h7;
  localparam logic [OPC_W-1:0] OP_LW   = 4'h8;
  localparam logic [OPC_W-1:0] OP_SW   = 4'h9;
  localparam logic [OPC_W-1:0] OP_LHB  = 4'hA;
  localparam logic [OPC_W-1:0] OP_LLB  = 4'hB;
  localparam logic [OPC_W-1:0] OP_B    = 4'hC;
  localparam logic [OPC_W-1:0] OP_JAL  = 4'hD;
  localparam logic [OPC_W-1:0] OP_JR   = 4'hE;
  localparam logic [OPC_W-1:0] OP_HLT  = 4'hF;

  // ALU operation encodings shared with the EX stage
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_NOR = 4'h3;
  localparam logic [3:0] ALU_SLL = 4'h4;
  localparam logic [3:0] ALU_SRL = 4'h5;
  localparam logic [3:0] ALU_SRA = 4'h6;
  localparam logic [3:0] ALU_LHB = 4'h7;
  localparam logic [3:0] ALU_NOP = 4'hF;

  localparam logic [REG_AW-1:0] LINK      = REG_AW'(LINK_REG);
  localparam logic [SCNT_W-1:0] SCNT_LOAD = SCNT_W'(LOAD_LAT - 1);

  typedef struct packed {
    logic              vld;
    logic              rd_en1;
    logic              rd_en2;
    logic              wr_en;
    logic [REG_AW-1:0] rd_reg1;
    logic [REG_AW-1:0] rd_reg2;
    logic [REG_AW-1:0] wr_reg;
    logic              mem_rd;
    logic              mem_wr;
    logic              mem2reg;
    logic              saw_br;
    logic              saw_j;
    logic              alu_src;
    logic              cond_z;
    logic [3:0]        alu_op;
    logic [3:0]        sh_amt;
  } ex_t;

  logic [OPC_W-1:0]  w_opc;
  logic [REG_AW-1:0] w_f_rd;
  logic [REG_AW-1:0] w_f_rs;
  logic [REG_AW-1:0] w_f_rt;
  logic [3:0]        w_sh;

  ex_t               w_dec;
  ex_t               w_bubble;
  ex_t               w_nxt_ex;
  ex_t               r_ex;
  logic [SCNT_W-1:0] w_nxt_scnt;
  logic [SCNT_W-1:0] r_scnt;
  logic              w_nxt_hlt;
  logic              r_hlt;
  logic              w_src1_hit;
  logic              w_src2_hit;
  logic              w_haz;
  logic              w_busy;

  assign w_opc  = instr_in[INSTR_W-1 -: OPC_W];
  assign w_f_rd = instr_in[3*REG_AW-1 -: REG_AW];
  assign w_f_rs = instr_in[2*REG_AW-1 -: REG_AW];
  assign w_f_rt = instr_in[REG_AW-1:0];
  assign w_sh   = instr_in[3:0];

  // Empty EX slot: nothing valid, nothing enabled, ALU idle
  always_comb begin
    w_bubble        = '0;
    w_bubble.alu_op = ALU_NOP;
  end

  // Combinational decode of the instruction currently in ID
  always_comb begin
    w_dec         = '0;
    w_dec.vld     = 1'b1;
    w_dec.rd_en1  = 1'b1;
    w_dec.wr_en   = 1'b1;
    w_dec.rd_reg1 = w_f_rs;
    w_dec.rd_reg2 = w_f_rt;
    w_dec.wr_reg  = w_f_rd;
    w_dec.alu_op  = ALU_NOP;
    w_dec.sh_amt  = w_sh;
    case (w_opc)
      OP_ADD:  begin w_dec.rd_en2 = 1'b1; w_dec.alu_op = ALU_ADD; end
      OP_ADDZ: begin
        w_dec.rd_en2 = 1'b1;
        w_dec.alu_op = ALU_ADD;
        w_dec.cond_z = 1'b1;
      end
      OP_SUB:  begin w_dec.rd_en2 = 1'b1; w_dec.alu_op = ALU_SUB; end
      OP_AND:  begin w_dec.rd_en2 = 1'b1; w_dec.alu_op = ALU_AND; end
      OP_NOR:  begin w_dec.rd_en2 = 1'b1; w_dec.alu_op = ALU_NOR; end
      OP_SLL:  w_dec.alu_op = ALU_SLL;
      OP_SRL:  w_dec.alu_op = ALU_SRL;
      OP_SRA:  w_dec.alu_op = ALU_SRA;
      OP_LW:   begin w_dec.mem_rd = 1'b1; w_dec.alu_op = ALU_ADD; end
      OP_SW:   begin
        w_dec.wr_en   = 1'b0;
        w_dec.mem_wr  = 1'b1;
        w_dec.rd_reg2 = w_f_rd;
        w_dec.alu_op  = ALU_ADD;
      end
      OP_LHB:  begin w_dec.rd_reg1 = w_f_rd; w_dec.alu_op = ALU_LHB; end
      OP_LLB:  begin w_dec.rd_reg1 = '0; w_dec.alu_op = ALU_ADD; end
      OP_B:    begin
        w_dec.rd_en1 = 1'b0;
        w_dec.wr_en  = 1'b0;
        w_dec.saw_br = 1'b1;
      end
      OP_JAL:  begin
        w_dec.rd_en1 = 1'b0;
        w_dec.wr_reg = LINK;
        w_dec.saw_j  = 1'b1;
      end
      OP_JR:   begin
        w_dec.rd_en2  = 1'b1;
        w_dec.wr_en   = 1'b0;
        w_dec.rd_reg1 = LINK;
        w_dec.rd_reg2 = '0;
        w_dec.saw_j   = 1'b1;
        w_dec.alu_op  = ALU_ADD;
      end
      OP_HLT:  begin w_dec.rd_en1 = 1'b0; w_dec.wr_en = 1'b0; end
      default: ;
    endcase
    w_dec.mem2reg = w_dec.mem_rd;
    // LLB and SW already have rd_en2 low, so the immediate path follows rd_en2
    w_dec.alu_src = w_dec.rd_en2;
  end

  // Load in EX whose destination is a source of the instruction in ID.
  // The SW store-data register is a real source even though rd_en2 is low.
  assign w_src1_hit = w_dec.rd_en1 & (w_dec.rd_reg1 == r_ex.wr_reg);
  assign w_src2_hit = (w_dec.rd_en2 | w_dec.mem_wr) & (w_dec.rd_reg2 == r_ex.wr_reg);
  assign w_haz      = r_ex.vld & r_ex.mem_rd & (r_ex.wr_reg != '0) & instr_vld
                    & (w_src1_hit | w_src2_hit);
  assign w_busy     = w_haz | (r_scnt != '0);

  // A flush kills the held instruction, so it overrides a stall but never a halt
  assign id_stall = (w_busy | r_hlt) & (~flush | r_hlt);

  // Next EX bundle, stall counter and halt flag: halt > flush > stall > normal
  always_comb begin
    w_nxt_ex   = w_bubble;
    w_nxt_scnt = r_scnt;
    w_nxt_hlt  = r_hlt;
    if (r_hlt) begin
      w_nxt_ex = w_bubble;
    end else if (flush) begin
      w_nxt_scnt = '0;
    end else if (w_busy) begin
      if (r_scnt != '0) begin
        w_nxt_scnt = r_scnt - SCNT_W'(1);
      end else begin
        w_nxt_scnt = SCNT_LOAD;
      end
    end else if (instr_vld) begin
      w_nxt_ex  = w_dec;
      w_nxt_hlt = (w_opc == OP_HLT);
    end
  end

  // ID/EX pipeline register, stall counter and sticky halt
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex   <= w_bubble;
      r_scnt <= '0;
      r_hlt  <= 1'b0;
    end else begin
      r_ex   <= w_nxt_ex;
      r_scnt <= w_nxt_scnt;
      r_hlt  <= w_nxt_hlt;
    end
  end

  assign hlt        = r_hlt;
  assign ex_vld     = r_ex.vld;
  assign ex_rdEn1   = r_ex.rd_en1;
  assign ex_rdEn2   = r_ex.rd_en2;
  assign ex_wrRegEn = r_ex.wr_en;
  assign ex_rdReg1  = r_ex.rd_reg1;
  assign ex_rdReg2  = r_ex.rd_reg2;
  assign ex_wrReg   = r_ex.wr_reg;
  assign ex_memRd   = r_ex.mem_rd;
  assign ex_memWr   = r_ex.mem_wr;
  assign ex_mem2reg = r_ex.mem2reg;
  assign ex_sawBr   = r_ex.saw_br;
  assign ex_sawJ    = r_ex.saw_j;
  assign ex_aluSrc  = r_ex.alu_src;
  assign ex_condZ   = r_ex.cond_z;
  assign ex_aluOp   = r_ex.alu_op;
  assign ex_shAmt   = r_ex.sh_amt;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Bench for decode_ctrl_pipe: two instances (LOAD_LAT=1 and LOAD_LAT=3),
// a cycle-level behavioural model checked every cycle, plus directed literals.
module tb_decode_ctrl_pipe;

  localparam logic [3:0] OP_ADDZ = 4'h1, OP_LW = 4'h8, OP_SW = 4'h9;
  localparam logic [3:0] OP_B = 4'hC, OP_JAL = 4'hD, OP_JR = 4'hE, OP_HLT = 4'hF;
  localparam logic [3:0] A_ADD = 4'h0, A_SUB = 4'h1, A_AND = 4'h2, A_NOR = 4'h3;
  localparam logic [3:0] A_SLL = 4'h4, A_SRL = 4'h5, A_SRA = 4'h6, A_LHB = 4'h7;
  localparam logic [3:0] A_NOP = 4'hF;

  typedef struct packed {
    logic       vld, rd_en1, rd_en2, wr_en;
    logic [3:0] rd_reg1, rd_reg2, wr_reg;
    logic       mem_rd, mem_wr, mem2reg, saw_br, saw_j, alu_src, cond_z;
    logic [3:0] alu_op, sh_amt;
  } bun_t;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] t_instr[2];
  logic        t_vld[2], t_flush[2], t_rstn[2];
  logic [15:0] p_instr[2];
  logic        p_vld[2], p_flush[2], p_rstn[2];

  logic       o_stall[2], o_hlt[2], o_vld[2], o_rd_en1[2], o_rd_en2[2], o_wr_en[2];
  logic [3:0] o_rd_reg1[2], o_rd_reg2[2], o_wr_reg[2];
  logic       o_mem_rd[2], o_mem_wr[2], o_mem2reg[2], o_saw_br[2], o_saw_j[2];
  logic       o_alu_src[2], o_cond_z[2];
  logic [3:0] o_alu_op[2], o_sh_amt[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    decode_ctrl_pipe #(.INSTR_W(16), .REG_AW(4), .LINK_REG(15),
                       .LOAD_LAT((g == 0) ? 1 : 3)) u_dut (
      .clk(clk), .rst_n(t_rstn[g]), .instr_in(t_instr[g]), .instr_vld(t_vld[g]),
      .flush(t_flush[g]), .id_stall(o_stall[g]), .hlt(o_hlt[g]), .ex_vld(o_vld[g]),
      .ex_rdEn1(o_rd_en1[g]), .ex_rdEn2(o_rd_en2[g]), .ex_wrRegEn(o_wr_en[g]),
      .ex_rdReg1(o_rd_reg1[g]), .ex_rdReg2(o_rd_reg2[g]), .ex_wrReg(o_wr_reg[g]),
      .ex_memRd(o_mem_rd[g]), .ex_memWr(o_mem_wr[g]), .ex_mem2reg(o_mem2reg[g]),
      .ex_sawBr(o_saw_br[g]), .ex_sawJ(o_saw_j[g]), .ex_aluSrc(o_alu_src[g]),
      .ex_condZ(o_cond_z[g]), .ex_aluOp(o_alu_op[g]), .ex_shAmt(o_sh_amt[g])
    );
  end

  int n_vec, n_err, cyc;

  task automatic check(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[dut%0d] t=%0t: got %0h, expected %0h", nm, k, $time, act, exp);
    end
  endtask

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic bun_t bubble();
    bun_t b;
    b = '0;
    b.alu_op = A_NOP;
    return b;
  endfunction

  // Per-opcode control table written from the decode rules
  function automatic bun_t dec(input logic [15:0] ins);
    bun_t b;
    logic [3:0] rd, rs, rt;
    rd = ins[11:8]; rs = ins[7:4]; rt = ins[3:0];
    b = '0;
    b.vld = 1'b1; b.sh_amt = rt; b.alu_op = A_NOP;
    b.rd_reg1 = rs; b.rd_reg2 = rt; b.wr_reg = rd;
    case (ins[15:12])
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4: begin
        b.rd_en1 = 1; b.rd_en2 = 1; b.wr_en = 1; b.alu_src = 1;
        case (ins[15:12])
          4'h2: b.alu_op = A_SUB;
          4'h3: b.alu_op = A_AND;
          4'h4: b.alu_op = A_NOR;
          default: b.alu_op = A_ADD;
        endcase
        b.cond_z = (ins[15:12] == OP_ADDZ);
      end
      4'h5: begin b.rd_en1 = 1; b.wr_en = 1; b.alu_op = A_SLL; end
      4'h6: begin b.rd_en1 = 1; b.wr_en = 1; b.alu_op = A_SRL; end
      4'h7: begin b.rd_en1 = 1; b.wr_en = 1; b.alu_op = A_SRA; end
      4'h8: begin b.rd_en1 = 1; b.wr_en = 1; b.mem_rd = 1; b.mem2reg = 1; b.alu_op = A_ADD; end
      4'h9: begin b.rd_en1 = 1; b.mem_wr = 1; b.rd_reg2 = rd; b.alu_op = A_ADD; end
      4'hA: begin b.rd_en1 = 1; b.wr_en = 1; b.rd_reg1 = rd; b.alu_op = A_LHB; end
      4'hB: begin b.rd_en1 = 1; b.wr_en = 1; b.rd_reg1 = 4'd0; b.alu_op = A_ADD; end
      4'hC: b.saw_br = 1;
      4'hD: begin b.wr_en = 1; b.wr_reg = 4'd15; b.saw_j = 1; end
      4'hE: begin
        b.rd_en1 = 1; b.rd_en2 = 1; b.alu_src = 1; b.rd_reg1 = 4'd15;
        b.rd_reg2 = 4'd0; b.saw_j = 1; b.alu_op = A_ADD;
      end
      default: ;
    endcase
    return b;
  endfunction

  function automatic bun_t dut_bun(input int k);
    bun_t b;
    b = '{o_vld[k], o_rd_en1[k], o_rd_en2[k], o_wr_en[k], o_rd_reg1[k], o_rd_reg2[k],
          o_wr_reg[k], o_mem_rd[k], o_mem_wr[k], o_mem2reg[k], o_saw_br[k], o_saw_j[k],
          o_alu_src[k], o_cond_z[k], o_alu_op[k], o_sh_amt[k]};
    return b;
  endfunction

  // Model state: EX slot, halt flag, stall window end (in cycles), validity
  bun_t m_ex[2];
  logic m_hlt[2], m_ok[2];
  int   m_rel[2];
  bun_t md;
  logic mh, mw, ms;

  // Compare DUT against model, then advance the model with this cycle's inputs
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      md = dec(t_instr[k]);
      mw = (cyc < m_rel[k]);
      mh = m_ex[k].vld && m_ex[k].mem_rd && (m_ex[k].wr_reg != 4'd0) && t_vld[k] &&
           ((md.rd_en1 && (md.rd_reg1 == m_ex[k].wr_reg)) ||
            ((md.rd_en2 || md.mem_wr) && (md.rd_reg2 == m_ex[k].wr_reg)));
      ms = (mh || mw || m_hlt[k]) && (!t_flush[k] || m_hlt[k]);
      if (m_ok[k]) begin
        check("ex_bundle", k, 32'(dut_bun(k)), 32'(m_ex[k]));
        check("hlt", k, 32'(o_hlt[k]), 32'(m_hlt[k]));
        check("id_stall", k, 32'(o_stall[k]), 32'(ms));
      end
      if (!t_rstn[k]) begin
        m_ex[k] = bubble(); m_hlt[k] = 1'b0; m_rel[k] = 0; m_ok[k] = 1'b1;
      end else if (m_hlt[k]) begin
        m_ex[k] = bubble();
      end else if (t_flush[k]) begin
        m_ex[k] = bubble(); m_rel[k] = 0;
      end else if (ms) begin
        m_ex[k] = bubble();
        if (!mw) m_rel[k] = cyc + lat(k);
      end else if (t_vld[k]) begin
        m_ex[k] = md;
        m_hlt[k] = (t_instr[k][15:12] == OP_HLT);
      end else begin
        m_ex[k] = bubble();
      end
    end
    cyc++;
  end

  task automatic set(input int k, input logic [15:0] i, input logic v, input logic f,
                     input logic r);
    p_instr[k] = i; p_vld[k] = v; p_flush[k] = f; p_rstn[k] = r;
  endtask

  // One cycle: inputs change just after posedge, checks happen after negedge
  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      t_instr[k] = p_instr[k]; t_vld[k] = p_vld[k];
      t_flush[k] = p_flush[k]; t_rstn[k] = p_rstn[k];
    end
    @(negedge clk);
    #1;
  endtask

  logic [15:0] ins;
  int op;

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    for (int k = 0; k < 2; k++) begin
      m_ok[k] = 1'b0; m_hlt[k] = 1'b0; m_rel[k] = 0; m_ex[k] = bubble();
      t_instr[k] = 16'h0123; t_vld[k] = 1'b1; t_flush[k] = 1'b0; t_rstn[k] = 1'b0;
      set(k, 16'h0123, 1'b1, 1'b0, 1'b0);
    end
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      check("rst_vld", k, 32'(o_vld[k]), 32'd0);
      check("rst_aluop", k, 32'(o_alu_op[k]), 32'hF);
      check("rst_wrreg", k, 32'(o_wr_reg[k]), 32'd0);
      check("rst_hlt", k, 32'(o_hlt[k]), 32'd0);
      check("rst_stall", k, 32'(o_stall[k]), 32'd0);
    end

    // First ADD R1,R2,R3 after reset
    set(0, 16'h0123, 1, 0, 1); set(1, 16'h0000, 0, 0, 1); tick();
    set(0, 16'h0000, 0, 0, 1); tick();
    check("add_vld", 0, 32'(o_vld[0]), 32'd1);
    check("add_rs", 0, 32'(o_rd_reg1[0]), 32'd2);
    check("add_rt", 0, 32'(o_rd_reg2[0]), 32'd3);
    check("add_rd", 0, 32'(o_wr_reg[0]), 32'd1);
    check("add_alu", 0, 32'(o_alu_op[0]), 32'(A_ADD));

    // Decode sweep, each opcode (except HLT) followed by an idle slot
    for (op = 0; op < 15; op++) begin
      ins = {4'(op), 12'h123};
      set(0, ins, 1, 0, 1); tick();
      set(0, 16'h0000, 0, 0, 1); tick();
      if (ins[15:12] == OP_JAL) begin
        check("jal_wr", 0, 32'(o_wr_reg[0]), 32'd15);
        check("jal_j", 0, 32'(o_saw_j[0]), 32'd1);
      end
      if (ins[15:12] == OP_JR) begin
        check("jr_rs", 0, 32'(o_rd_reg1[0]), 32'd15);
        check("jr_rt", 0, 32'(o_rd_reg2[0]), 32'd0);
      end
      if (ins[15:12] == OP_ADDZ) check("addz_cz", 0, 32'(o_cond_z[0]), 32'd1);
      if (ins[15:12] == OP_SW) begin
        check("sw_rt", 0, 32'(o_rd_reg2[0]), 32'd1);
        check("sw_asrc", 0, 32'(o_alu_src[0]), 32'd0);
        check("sw_mw", 0, 32'(o_mem_wr[0]), 32'd1);
      end
      if (ins[15:12] == OP_B) check("b_wren", 0, 32'(o_wr_en[0]), 32'd0);
      if (ins[15:12] == OP_LW) check("lw_m2r", 0, 32'(o_mem2reg[0]), 32'd1);
    end

    // Load-use, LOAD_LAT=1: LW R3 then ADD R4,R3,R5
    set(0, 16'h8320, 1, 0, 1); tick();
    set(0, 16'h0435, 1, 0, 1); tick();
    check("lu1_stall_a", 0, 32'(o_stall[0]), 32'd1);
    tick();
    check("lu1_stall_b", 0, 32'(o_stall[0]), 32'd0);
    check("lu1_bubble", 0, 32'(o_vld[0]), 32'd0);
    set(0, 16'h0000, 0, 0, 1); tick();
    check("lu1_add_vld", 0, 32'(o_vld[0]), 32'd1);
    check("lu1_add_rd", 0, 32'(o_wr_reg[0]), 32'd4);

    // Load-use, LOAD_LAT=3
    set(1, 16'h8320, 1, 0, 1); tick();
    set(1, 16'h0435, 1, 0, 1); tick();
    check("lu3_stall_1", 1, 32'(o_stall[1]), 32'd1);
    tick(); check("lu3_stall_2", 1, 32'(o_stall[1]), 32'd1);
    tick(); check("lu3_stall_3", 1, 32'(o_stall[1]), 32'd1);
    tick(); check("lu3_stall_end", 1, 32'(o_stall[1]), 32'd0);
    check("lu3_bubble", 1, 32'(o_vld[1]), 32'd0);
    set(1, 16'h0000, 0, 0, 1); tick();
    check("lu3_add_vld", 1, 32'(o_vld[1]), 32'd1);
    check("lu3_add_rs", 1, 32'(o_rd_reg1[1]), 32'd3);

    // No hazard: R0 destination, and LLB (reads R0 only)
    set(0, 16'h8020, 1, 0, 1); tick();
    set(0, 16'h0405, 1, 0, 1); tick();
    check("nohaz_r0", 0, 32'(o_stall[0]), 32'd0);
    set(0, 16'h8320, 1, 0, 1); tick();
    set(0, 16'hB345, 1, 0, 1); tick();
    check("nohaz_llb", 0, 32'(o_stall[0]), 32'd0);
    set(0, 16'h0000, 0, 0, 1); tick();

    // Flush with SUB in ID
    set(0, 16'h2123, 1, 1, 1); tick();
    set(0, 16'h0000, 0, 0, 1); tick();
    check("flush_vld", 0, 32'(o_vld[0]), 32'd0);

    // Flush during a LOAD_LAT=3 stall must clear the counter
    set(1, 16'h8320, 1, 0, 1); tick();
    set(1, 16'h2435, 1, 0, 1); tick();
    check("fst_stall", 1, 32'(o_stall[1]), 32'd1);
    set(1, 16'h2435, 1, 1, 1); tick();
    check("fst_gated", 1, 32'(o_stall[1]), 32'd0);
    set(1, 16'h0000, 0, 0, 1); tick();
    check("fst_vld", 1, 32'(o_vld[1]), 32'd0);
    check("fst_cleared", 1, 32'(o_stall[1]), 32'd0);

    // Halt then ADD: ADD never enters EX
    set(0, 16'hF000, 1, 0, 1); tick();
    set(0, 16'h0123, 1, 0, 1); tick();
    check("hlt_set", 0, 32'(o_hlt[0]), 32'd1);
    check("hlt_exvld", 0, 32'(o_vld[0]), 32'd1);
    check("hlt_nop", 0, 32'(o_alu_op[0]), 32'(A_NOP));
    check("hlt_stall", 0, 32'(o_stall[0]), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hlt_frozen_vld", 0, 32'(o_vld[0]), 32'd0);
      check("hlt_frozen_stall", 0, 32'(o_stall[0]), 32'd1);
    end
    set(0, 16'h0123, 1, 1, 1); tick();
    check("hlt_flush_stall", 0, 32'(o_stall[0]), 32'd1);
    set(0, 16'h0123, 1, 0, 0); tick();
    set(0, 16'h0000, 0, 0, 1); tick();
    check("hlt_rst_hlt", 0, 32'(o_hlt[0]), 32'd0);
    check("hlt_rst_stall", 0, 32'(o_stall[0]), 32'd0);

    // Flush together with HLT in ID discards the HLT
    set(1, 16'hF000, 1, 1, 1); tick();
    set(1, 16'h0000, 0, 0, 1); tick();
    check("hltfl_hlt", 1, 32'(o_hlt[1]), 32'd0);
    check("hltfl_vld", 1, 32'(o_vld[1]), 32'd0);

    // Mixed traffic on a small register set; fetch holds while stalled
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (!o_stall[k]) begin
          op = int'($urandom_range(0, 15));
          if (op == 15 && $urandom_range(0, 3) != 0) op = 8;
          ins = {4'(op), 2'b00, 2'($urandom_range(0, 3)), 2'b00,
                 2'($urandom_range(0, 3)), 2'b00, 2'($urandom_range(0, 3))};
          p_instr[k] = ins;
          p_vld[k] = ($urandom_range(0, 4) != 0);
        end
        p_flush[k] = ($urandom_range(0, 9) == 0);
        p_rstn[k] = ($urandom_range(0, 39) != 0);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
